// File: rtl/cd_tx_ram.sv
// cd_tx_ram: multi-page TX frame buffer between the host register port and the CDBUS serializer.
// Latency: commit/release/abort act on the next edge; rd_byte valid one cycle after rd_en.
// Backpressure: has_free low blocks host writes/commits (commit then pulses switch_fail); rd_done on an empty page is ignored.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   wr_byte/wr_addr/wr_en        host byte write into the current write page
//   switch/wr_len                commit current write page with its frame length
//   has_free, switch_fail        write page free / commit rejected pulse
//   rd_addr/rd_en, rd_byte       TX byte read from current read page (1-cycle latency)
//   rd_len, rd_done              length of current read page / release it
//   abort                        flush all pages (lengths and data kept)
//   pending, pend_cnt            committed-but-unsent page status

// One 256x8 single-port page with a registered read port.
// Latency: read data one cycle after an enabled read; writes land on the edge.
// Backpressure: none; the output register holds whenever no read is enabled.
module cd_tx_ram_page (
   input  logic       clk,
   input  logic       en_i,
   input  logic       we_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o
);

   logic [7:0] mem_q [256];
   logic [7:0] dout_q;

   // Write cycles leave dout_q untouched so the TX side sees a stable
   // byte until its own next read of this page.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= din_i;
         end else begin
            dout_q <= mem_q[addr_i];
         end
      end
   end

   assign dout_o = dout_q;

endmodule

module cd_tx_ram #(
   parameter int N_WIDTH = 1
) (
   input  logic               clk,
   input  logic               reset_n,

   input  logic [7:0]         wr_byte,
   input  logic [7:0]         wr_addr,
   input  logic               wr_en,
   input  logic               switch,
   input  logic [7:0]         wr_len,
   output logic               has_free,
   output logic               switch_fail,

   output logic [7:0]         rd_byte,
   input  logic [7:0]         rd_addr,
   input  logic               rd_en,
   output logic [7:0]         rd_len,
   input  logic               rd_done,

   input  logic               abort,
   output logic               pending,
   output logic [N_WIDTH:0]   pend_cnt
);

   localparam int PAGES = 2 ** N_WIDTH;

   localparam logic [N_WIDTH-1:0] SEL_ONE = N_WIDTH'(1);
   localparam logic [N_WIDTH:0]   CNT_ONE = (N_WIDTH + 1)'(1);

   // ------------------------------------------------------------------
   // Page bookkeeping state
   // ------------------------------------------------------------------
   logic [PAGES-1:0]   dirty_q,       dirty_d;
   logic [N_WIDTH-1:0] wr_sel_q,      wr_sel_d;
   logic [N_WIDTH-1:0] rd_sel_q,      rd_sel_d;
   logic [7:0]         len_q [PAGES];
   logic [7:0]         len_d [PAGES];
   logic [N_WIDTH:0]   pend_cnt_q,    pend_cnt_d;
   logic               switch_fail_q, switch_fail_d;

   // Page that served the most recent TX read; steers rd_byte so the
   // output stays tied to that access even after rd_sel moves on.
   logic [N_WIDTH-1:0] rd_pg_q,       rd_pg_d;

   logic               wr_page_dirty;
   logic               rd_page_dirty;
   logic               commit_ok;
   logic               commit_fail;
   logic               release_ok;
   logic               wr_ok;

   // All decisions use the pre-edge dirty bits. A commit needs the write
   // page clean and a release needs the read page dirty, so the two can
   // never target the same page in one cycle.
   assign wr_page_dirty = dirty_q[wr_sel_q];
   assign rd_page_dirty = dirty_q[rd_sel_q];
   assign commit_ok     = switch  & ~wr_page_dirty & ~abort;
   assign commit_fail   = switch  &  wr_page_dirty & ~abort;
   assign release_ok    = rd_done &  rd_page_dirty & ~abort;

   // Host writes into a queued page are dropped so a committed frame
   // cannot be corrupted while it waits for the serializer.
   assign wr_ok = wr_en & ~wr_page_dirty & ~abort & reset_n;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      dirty_d       = dirty_q;
      wr_sel_d      = wr_sel_q;
      rd_sel_d      = rd_sel_q;
      len_d         = len_q;
      pend_cnt_d    = pend_cnt_q;
      switch_fail_d = 1'b0;

      if (abort) begin
         // Flush ownership only; lengths and page data survive.
         dirty_d    = '0;
         wr_sel_d   = '0;
         rd_sel_d   = '0;
         pend_cnt_d = '0;
      end else begin
         if (commit_fail) begin
            switch_fail_d = 1'b1;
         end

         if (commit_ok) begin
            dirty_d[wr_sel_q] = 1'b1;
            len_d[wr_sel_q]   = wr_len;
            wr_sel_d          = wr_sel_q + SEL_ONE;
         end

         if (release_ok) begin
            dirty_d[rd_sel_q] = 1'b0;
            rd_sel_d          = rd_sel_q + SEL_ONE;
         end

         // A simultaneous commit and release cancel in the count.
         unique case ({commit_ok, release_ok})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_ONE;
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_ONE;
            default: pend_cnt_d = pend_cnt_q;
         endcase
      end
   end

   always_comb begin
      rd_pg_d = rd_pg_q;
      if (rd_en) begin
         rd_pg_d = rd_sel_q;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dirty_q       <= '0;
         wr_sel_q      <= '0;
         rd_sel_q      <= '0;
         pend_cnt_q    <= '0;
         switch_fail_q <= 1'b0;
         rd_pg_q       <= '0;
         for (int p = 0; p < PAGES; p++) begin
            len_q[p] <= 8'h00;
         end
      end else begin
         dirty_q       <= dirty_d;
         wr_sel_q      <= wr_sel_d;
         rd_sel_q      <= rd_sel_d;
         pend_cnt_q    <= pend_cnt_d;
         switch_fail_q <= switch_fail_d;
         rd_pg_q       <= rd_pg_d;
         for (int p = 0; p < PAGES; p++) begin
            len_q[p] <= len_d[p];
         end
      end
   end

   // ------------------------------------------------------------------
   // Page RAMs
   // ------------------------------------------------------------------
   logic [7:0] page_dout [PAGES];

   for (genvar i = 0; i < PAGES; i++) begin : g_page
      localparam logic [N_WIDTH-1:0] PG = N_WIDTH'(i);

      logic       wr_hit;
      logic       rd_hit;
      logic [7:0] addr;

      assign wr_hit = wr_ok & (wr_sel_q == PG);
      assign rd_hit = rd_en & (rd_sel_q == PG);
      // The host write owns the address port when both hit one page.
      assign addr   = wr_hit ? wr_addr : rd_addr;

      cd_tx_ram_page u_page (
         .clk    (clk),
         .en_i   (wr_hit | rd_hit),
         .we_i   (wr_hit),
         .addr_i (addr),
         .din_i  (wr_byte),
         .dout_o (page_dout[i])
      );
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign has_free    = ~wr_page_dirty;
   assign pending     = |dirty_q;
   assign pend_cnt    = pend_cnt_q;
   assign switch_fail = switch_fail_q;
   assign rd_len      = len_q[rd_sel_q];
   assign rd_byte     = page_dout[rd_pg_q];

`ifndef SYNTHESIS
   // The counter is a cached popcount of the dirty bits.
   a_pend_cnt_matches_dirty : assert property (
      @(posedge clk) disable iff (!reset_n)
         pend_cnt_q == (N_WIDTH + 1)'($countones(dirty_q))
   );
`endif

endmodule
